// File: rtl/mult_core_sched.sv
// rtl/mult_core_sched.sv - round-robin scheduler sharing one MAC core between pNUM_CH channels
// Optional WAIT_RES timeout with oerr output: define MULT_CORE_SCHED_TIMEOUT_EN.
module mult_core_sched #(
    parameter int pNUM_CH          = 4,
    parameter int pDATA_IN_W       = 8,
    parameter int pNUM_OF_ELEMENTS = 9,
    parameter int pACC_W           = 20,
    parameter int pCH_W            = $clog2(pNUM_CH)
`ifdef MULT_CORE_SCHED_TIMEOUT_EN
    ,
    parameter int pTIMEOUT         = 64
`endif
) (
    input  logic                               iclk,
    input  logic                               irst,
    input  logic [pNUM_CH-1:0]                 ireq,
    output logic [pNUM_CH-1:0]                 ogrant,
    input  logic [pNUM_CH-1:0]                 ich_valid,
    input  logic [pNUM_CH*2*pDATA_IN_W-1:0]    ich_data,
    output logic [pNUM_CH-1:0]                 och_ready,
    output logic [2*pDATA_IN_W-1:0]            ocore_data,
    output logic                               ocore_data_en,
    input  logic [pACC_W-1:0]                  icore_odata,
    input  logic                               icore_odata_ready,
    output logic [pACC_W-1:0]                  oresult,
    output logic [pCH_W-1:0]                   oresult_ch,
    output logic                               oresult_valid,
    output logic                               obusy
`ifdef MULT_CORE_SCHED_TIMEOUT_EN
    ,
    output logic                               oerr
`endif
);

    localparam int PW    = 2 * pDATA_IN_W;
    localparam int CNT_W = $clog2(pNUM_OF_ELEMENTS + 1);

    typedef enum logic [1:0] {IDLE, GRANT, STREAM, WAIT_RES} state_t;

    state_t            state, state_nxt;
    logic [pCH_W-1:0]  sel;
    logic [pCH_W-1:0]  ptr;
    logic [CNT_W-1:0]  cnt;
    logic [pCH_W-1:0]  pick;
    logic              found;
    logic              hs;
    logic              last_beat;
    logic              res_take;
    logic              res_done;

`ifdef MULT_CORE_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(pTIMEOUT + 1);
    logic [TO_W-1:0]   tcnt;
    logic              to_hit;
    assign to_hit = (state == WAIT_RES) && !icore_odata_ready && (tcnt == TO_W'(pTIMEOUT - 1));
`endif

    // Search starts one past the last served channel; wrap by compare so non power-of-two counts work.
    always_comb begin
        int               j;
        logic [pCH_W-1:0] idx;
        pick  = '0;
        found = 1'b0;
        j     = 0;
        idx   = '0;
        for (int i = 0; i < pNUM_CH; i++) begin
            j = int'(ptr) + 1 + i;
            if (j > pNUM_CH - 1) j = j - pNUM_CH;
            idx = pCH_W'(j);
            if (!found && ireq[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign och_ready = (state == STREAM) ? ogrant : '0;
    assign obusy     = (state != IDLE);
    assign hs        = (state == STREAM) && ich_valid[sel];
    assign last_beat = hs && (cnt == CNT_W'(pNUM_OF_ELEMENTS - 1));
    assign res_take  = (state == WAIT_RES) && icore_odata_ready;
`ifdef MULT_CORE_SCHED_TIMEOUT_EN
    assign res_done  = res_take || to_hit;
`else
    assign res_done  = res_take;
`endif

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (found) state_nxt = GRANT;
            GRANT:    state_nxt = STREAM;
            STREAM:   if (last_beat) state_nxt = WAIT_RES;
            WAIT_RES: if (res_done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            ogrant        <= '0;
            sel           <= '0;
            ptr           <= pCH_W'(pNUM_CH - 1);
            cnt           <= '0;
            ocore_data    <= '0;
            ocore_data_en <= 1'b0;
            oresult       <= '0;
            oresult_ch    <= '0;
            oresult_valid <= 1'b0;
`ifdef MULT_CORE_SCHED_TIMEOUT_EN
            tcnt          <= '0;
            oerr          <= 1'b0;
`endif
        end else begin
            ocore_data_en <= hs;
            oresult_valid <= 1'b0;
            if (hs) begin
                ocore_data <= ich_data[sel*PW +: PW];
                cnt        <= last_beat ? '0 : cnt + 1'b1;
            end
            if (state == IDLE && found) begin
                ogrant <= pNUM_CH'(1) << pick;
                sel    <= pick;
            end
            if (res_take) begin
                oresult       <= icore_odata;
                oresult_valid <= 1'b1;
            end
            if (res_done) begin
                oresult_ch <= sel;
                ptr        <= sel;
                ogrant     <= '0;
            end
`ifdef MULT_CORE_SCHED_TIMEOUT_EN
            oerr <= to_hit;
            if (state == WAIT_RES && !res_done) tcnt <= tcnt + 1'b1;
            else                                tcnt <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_mult_core_sched.sv
// tb/tb_mult_core_sched.sv - scoreboard bench for mult_core_sched with a behavioural MAC core
module tb_mult_core_sched;
    localparam int NCH = 4, DW = 8, NE = 9, AW = 20, CW = 2;

    logic                  iclk = 1'b0;
    logic                  irst;
    logic [NCH-1:0]        ireq;
    logic [NCH-1:0]        ogrant;
    logic [NCH-1:0]        ich_valid;
    logic [NCH*2*DW-1:0]   ich_data;
    logic [NCH-1:0]        och_ready;
    logic [2*DW-1:0]       ocore_data;
    logic                  ocore_data_en;
    logic [AW-1:0]         icore_odata;
    logic                  icore_odata_ready;
    logic [AW-1:0]         oresult;
    logic [CW-1:0]         oresult_ch;
    logic                  oresult_valid;
    logic                  obusy;
`ifdef MULT_CORE_SCHED_TIMEOUT_EN
    logic                  oerr;
`endif

    mult_core_sched #(
        .pNUM_CH(NCH), .pDATA_IN_W(DW), .pNUM_OF_ELEMENTS(NE), .pACC_W(AW), .pCH_W(CW)
    ) dut (
        .iclk(iclk), .irst(irst), .ireq(ireq), .ogrant(ogrant),
        .ich_valid(ich_valid), .ich_data(ich_data), .och_ready(och_ready),
        .ocore_data(ocore_data), .ocore_data_en(ocore_data_en),
        .icore_odata(icore_odata), .icore_odata_ready(icore_odata_ready),
        .oresult(oresult), .oresult_ch(oresult_ch), .oresult_valid(oresult_valid),
        .obusy(obusy)
`ifdef MULT_CORE_SCHED_TIMEOUT_EN
        , .oerr(oerr)
`endif
    );

    always #5 iclk = ~iclk;

    typedef struct { int res; int ch; } res_t;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [15:0]  op_q[$];
    int           opc_q[$];
    res_t         res_q[$];
    int           gnt_q[$];
    int           rdy_cyc = -10;
    bit           core_en = 1'b1;
    bit           spur_req = 1'b0;
    int           core_n = 0;
    int           core_acc = 0;
    int           dly = 0;
    logic [NCH-1:0] prev_grant = '0;

    always @(posedge iclk) cyc++;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Behavioural core: multiply-accumulate NE strobes, answer a few cycles later.
    initial begin
        icore_odata       = '0;
        icore_odata_ready = 1'b0;
        forever begin
            @(posedge iclk); #1;
            icore_odata_ready = 1'b0;
            if (!irst) begin
                core_n = 0; core_acc = 0; dly = 0;
            end else begin
                if (ocore_data_en) begin
                    core_acc += int'(ocore_data[7:0]) * int'(ocore_data[15:8]);
                    core_n++;
                end
                if (spur_req) begin
                    icore_odata_ready = 1'b1;
                    icore_odata       = 20'd12345;
                    spur_req          = 1'b0;
                end else if (core_n == NE && core_en) begin
                    if (dly == 3) begin
                        icore_odata_ready = 1'b1;
                        icore_odata       = AW'(core_acc);
                        rdy_cyc = cyc;
                        core_n = 0; core_acc = 0; dly = 0;
                    end else dly++;
                end
            end
        end
    end

    always @(negedge iclk) begin
        if (irst) begin
            if (ocore_data_en) begin
                if (op_q.size() == 0) chk("unexpected_strobe", 1, 0);
                else begin
                    chk("core_data", ocore_data, op_q.pop_front());
                    chk("strobe_latency", cyc, opc_q.pop_front() + 1);
                end
            end
            if (oresult_valid) begin
                if (res_q.size() == 0) chk("unexpected_result_valid", 1, 0);
                else begin
                    res_t e;
                    e = res_q.pop_front();
                    chk("result", oresult, e.res);
                    chk("result_ch", oresult_ch, e.ch);
                    chk("result_latency", cyc, rdy_cyc + 1);
                end
            end
            if (ogrant != 0 && prev_grant == 0) begin
                if (gnt_q.size() == 0) chk("unexpected_grant", ogrant, 0);
                else chk("grant", ogrant, 1 << gnt_q.pop_front());
            end
        end
        prev_grant = ogrant;
    end

    task automatic check_zero(input string tag);
        chk({tag, "_ogrant"}, ogrant, 0);
        chk({tag, "_och_ready"}, och_ready, 0);
        chk({tag, "_ocore_data"}, ocore_data, 0);
        chk({tag, "_ocore_data_en"}, ocore_data_en, 0);
        chk({tag, "_oresult"}, oresult, 0);
        chk({tag, "_oresult_ch"}, oresult_ch, 0);
        chk({tag, "_oresult_valid"}, oresult_valid, 0);
        chk({tag, "_obusy"}, obusy, 0);
    endtask

    task automatic burst(input int ch, input int w, input int stall_at, input int stall_len,
                         input int spur_at, input int abort_at, input bit drop_req);
        int beat = 0, n = 0, stalled = 0;
        bit hs, spur_done = 0;
        while (beat < NE && n < 300) begin
            if (beat == abort_at) begin
                irst = 1'b0; #1;
                check_zero("reset_mid_burst");
                op_q.delete(); opc_q.delete();
                ich_valid[ch] = 1'b0;
                return;
            end
            if (beat == spur_at && !spur_done) begin
                spur_req = 1'b1; spur_done = 1'b1;
            end
            if (beat == stall_at && stalled < stall_len) begin
                ich_valid[ch] = 1'b0; stalled++;
            end else begin
                ich_valid[ch] = 1'b1;
                ich_data[ch*16 +: 16] = {8'(w), 8'(beat)};
            end
            @(negedge iclk);
            hs = ich_valid[ch] && och_ready[ch];
            if (hs) begin
                op_q.push_back(ich_data[ch*16 +: 16]);
                opc_q.push_back(cyc);
            end
            @(posedge iclk); #1;
            if (hs) begin
                beat++;
                if (drop_req) ireq = '0;
            end
            n++;
        end
        ich_valid[ch] = 1'b0;
        chk("burst_beats", beat, NE);
        chk("ready_low_after_last", och_ready, 0);
        chk("busy_in_wait", obusy, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((res_q.size() != 0 || obusy || oresult_valid) && n < 300) begin
            @(posedge iclk); #1; n++;
        end
        if (n >= 300) chk("idle_timeout", n, 0);
    endtask

    initial begin
        irst = 1'b0; ireq = '0; ich_valid = '0; ich_data = '0;
        repeat (3) @(posedge iclk);
        #1;
        check_zero("reset");
        irst = 1'b1;
        @(posedge iclk); #1;

        ireq = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            int ch;
            ch = i % 4;
            gnt_q.push_back(ch);
            res_q.push_back('{36 * (ch + 1), ch});
            burst(ch, ch + 1, -1, 0, -1, -1, i == 7);
        end
        wait_idle();

        gnt_q.push_back(2); res_q.push_back('{72, 2});
        ireq = 4'b0100;
        burst(2, 2, -1, 0, -1, -1, 1);
        wait_idle();

        gnt_q.push_back(1); res_q.push_back('{108, 1});
        ireq = 4'b0010;
        burst(1, 3, 4, 5, -1, -1, 1);
        wait_idle();

        gnt_q.push_back(3); res_q.push_back('{36, 3});
        ireq = 4'b1000;
        burst(3, 1, -1, 0, 3, -1, 1);
        chk("spurious_ignored", oresult, 108);
        wait_idle();
        chk("result_after_spurious", oresult, 36);

        gnt_q.push_back(0);
        ireq = 4'b0001;
        burst(0, 5, -1, 0, -1, 3, 1);
        ireq = 4'b0010;
        repeat (2) @(posedge iclk);
        #1;
        irst = 1'b1;
        gnt_q.push_back(1); res_q.push_back('{36, 1});
        burst(1, 1, -1, 0, -1, -1, 1);
        wait_idle();

`ifdef MULT_CORE_SCHED_TIMEOUT_EN
        begin
            int n = 0;
            core_en = 1'b0;
            ireq = 4'b1001;
            gnt_q.push_back(3);
            burst(3, 1, -1, 0, -1, -1, 0);
            while (n < 200) begin
                @(negedge iclk);
                if (oerr) break;
                @(posedge iclk); #1;
                n++;
            end
            chk("timeout_cycles", n, 64);
            chk("timeout_result_ch", oresult_ch, 3);
            chk("timeout_result_hold", oresult, 36);
            gnt_q.push_back(0);
            res_q.push_back('{36, 0});
            core_n = 0; core_acc = 0; dly = 0;
            core_en = 1'b1;
            @(posedge iclk); #1;
            burst(0, 1, -1, 0, -1, -1, 1);
            wait_idle();
        end
`endif

        chk("grant_queue_drained", gnt_q.size(), 0);
        chk("operand_queue_drained", op_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
